// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encodings and enum.
package serial_sub_pkg;

  localparam logic [1:0] IdleEnc = 2'd0;
  localparam logic [1:0] RunEnc  = 2'd1;
  localparam logic [1:0] DoneEnc = 2'd2;

  typedef enum logic [1:0] {
    IDLE = IdleEnc,
    RUN  = RunEnc,
    DONE = DoneEnc
  } sub_state_t;

endpackage

// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for serial_sub.
// With SERIAL_SUB_FLAGS_EN defined, the zero/ovf result flags are added.
interface serial_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero;
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
`ifdef SERIAL_SUB_FLAGS_EN
    , input zero, ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
`ifdef SERIAL_SUB_FLAGS_EN
    , output zero, ovf
`endif
  );
endinterface

// File: rtl/serial_sub_full_sub.sv
// Combinational 1-bit full subtractor cell: d = x - y - bi, borrow-out bo.
module serial_sub_full_sub (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  // Difference bit and borrow generate/propagate.
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end
endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Optional result flags (zero, ovf) are built when SERIAL_SUB_FLAGS_EN is defined.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  serial_sub_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  sub_state_t       state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] diff_sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             a_msb_q;
  logic             b_msb_q;
  logic             zero_q;
  logic             ovf_q;
`endif

  logic             bit_d;
  logic             bit_bo;
  logic [WIDTH-1:0] diff_next;

  serial_sub_full_sub u_full_sub (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .bi (br_q),
    .d  (bit_d),
    .bo (bit_bo)
  );

  // Shift register contents once the current bit has been inserted at the MSB.
  always_comb begin
    diff_next = {bit_d, diff_sr_q[WIDTH-1:1]};
  end

  // FSM, operand shifters, counter, borrow and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      diff_sr_q   <= '0;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            br_q    <= bus.bin;
            cnt_q   <= '0;
            state_q <= RUN;
`ifdef SERIAL_SUB_FLAGS_EN
            // Operand MSBs are kept because the shifters lose them.
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          sa_q      <= sa_q >> 1;
          sb_q      <= sb_q >> 1;
          br_q      <= bit_bo;
          diff_sr_q <= diff_next;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q     <= DONE;
            diff_q      <= diff_next;
            bout_q      <= bit_bo;
            out_valid_q <= 1'b1;
`ifdef SERIAL_SUB_FLAGS_EN
            zero_q      <= (diff_next == '0);
            ovf_q       <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_d);
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is decoded from state; held low while reset is asserted.
  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial, multi-cycle subtractor: computes diff = a - b - bin, LSB first, one bit per clock.
- Uses a single 1-bit full-subtractor cell and a registered borrow.
- Arithmetic counterpart to the team's ripple adder datapath; used where area matters more than latency.
- Valid/ready on input and output; result is held until consumed.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- CNT_W, $clog2(WIDTH), width of the bit counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operands a, b, bin are presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  diff/bout are valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out (1 when a < b + bin, unsigned)

Behaviour:
- Single clock clk. Reset rst_n is synchronous, active-low; it is sampled only on the rising edge of clk.
- While rst_n=0: state=IDLE; in_ready=0; out_valid=0; diff=0; bout=0; shift regs, counter and borrow reg = 0.
- After reset release: in_ready=1.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0.
  - At an edge with in_valid=1: latch a→sa, b→sb, bin→br; cnt=0; go to RUN.
- RUN: in_ready=0, out_valid=0.
  - Each edge processes bit sa[0], sb[0], br:
    - d = sa[0] ^ sb[0] ^ br
    - br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)
  - sa and sb shift right by 1; d shifts into diff_sr at the MSB; cnt increments.
  - At the edge where cnt == WIDTH-1: go to DONE; diff = final diff_sr; bout = br_next; out_valid=1.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge. For WIDTH=8, the accept edge is E0 and out_valid is high after E8.
- DONE: out_valid=1; diff and bout are stable.
  - At an edge with out_ready=1: go to IDLE; out_valid=0; in_ready=1.
  - diff and bout keep their last value until the next DONE.
- No overlap between transactions: throughput is one result per WIDTH+2 cycles minimum.
- Boundary conditions:
  - in_valid outside IDLE is ignored.
  - out_ready outside DONE is ignored.
  - Changes on a, b or bin after the accepting edge have no effect.
  - bin=1 with a == b gives diff = all ones, bout=1.
  - a=0, b=all ones, bin=1 gives diff=0, bout=1 (wrap-around).
  - rst_n=0 in any state, including mid-RUN or DONE with out_ready=0, aborts the operation: result is discarded, out_valid=0 after that edge, state=IDLE.
  - A simultaneous in_valid and rst_n=0: reset wins.

Optional Feature:
- Macro: SERIAL_SUB_FLAGS_EN.
- Defined: adds outputs zero (1 bit) and ovf (1 bit).
  - Both are registered and updated with diff at the RUN→DONE edge.
  - zero = (diff == 0).
  - ovf = signed two's-complement overflow = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), using the latched operand MSBs.
  - Both reset to 0 and are held like diff.
- Undefined: the ports and logic do not exist; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg holds:
  - state enum type sub_state_t {IDLE, RUN, DONE}
  - localparam encodings for the states
- Sub-module full_sub: combinational 1-bit full subtractor.
  - Inputs x, y, bi; outputs d, bo.
  - Instantiated once in RUN's datapath.
- Top module contains the FSM, counter, shift registers and output registers.

Test Plan:
- Reset release → in_ready=1, out_valid=0, diff=0x00, bout=0.
- WIDTH=8, a=0x50, b=0x20, bin=0, accept at E0 → out_valid high after E8; diff=0x30, bout=0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1.
- a=0x10, b=0x10, bin=1 → diff=0xFF, bout=1. Then a=0x10, b=0x10, bin=0 → diff=0x00, bout=0, zero=1 (with SERIAL_SUB_FLAGS_EN).
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → diff/bout held, in_ready=0, new operands not taken. Raise out_ready → IDLE next cycle, next accept works.
- rst_n=0 for one edge at RUN cycle 4 → out_valid=0, diff=0, in_ready=1 after release. A following a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1 (flags enabled).
